sb_sram_slv: RTL and testbench

SB-bus slave endpoint that terminates the read (AR/R) and write (W/B) channels and drives one single-port synchronous SRAM macro with 1-cycle read latency. It sits at the slave side of the bus, typically behind an sb pipeline slice or the address decoder. It sustains one access per cycle: reads and writes share the SRAM port under round-robin arbitration. Out-of-window accesses are answered without touching the SRAM.

---
 rtl/sb_pkg.sv | 19 +
 rtl/sb_sram_slv_if.sv | 33 +++
 rtl/sb_rr_arb2.sv | 22 ++
 rtl/sb_sram_slv.sv | 97 +++++++++
 tb/tb_sb_sram_slv.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sb_pkg.sv
// Shared SB-bus definitions: response codes, bus widths and the read-response state record.
package sb_pkg;
    localparam int SB_AW = 32;
    localparam int SB_DW = 32;

    localparam logic SB_RESP_OKAY = 1'b0;
    localparam logic SB_RESP_ERR  = 1'b1;

    typedef logic [SB_AW-1:0]   sb_addr_t;
    typedef logic [SB_DW-1:0]   sb_data_t;
    typedef logic [SB_DW/8-1:0] sb_strb_t;

    // first: the SRAM output is still live this cycle; err: out-of-window read
    typedef struct packed {
        logic vld;
        logic first;
        logic err;
    } sb_rd_st_t;
endpackage

// File: rtl/sb_sram_slv_if.sv
// SB-bus read (AR/R) and write (W/B) channels between a master and a slave endpoint.
interface sb_sram_slv_if;
    import sb_pkg::*;

    logic     sb_arvalid;
    logic     sb_arready;
    sb_addr_t sb_araddr;
    logic     sb_rvalid;
    logic     sb_rready;
    sb_data_t sb_rdata;
    logic     sb_wvalid;
    logic     sb_wready;
    sb_addr_t sb_waddr;
    sb_data_t sb_wdata;
    sb_strb_t sb_wstrb;
    logic     sb_bvalid;
    logic     sb_bready;
    logic     sb_bresp;

    modport master (
        output sb_arvalid, sb_araddr, sb_rready,
        output sb_wvalid, sb_waddr, sb_wdata, sb_wstrb, sb_bready,
        input  sb_arready, sb_rvalid, sb_rdata,
        input  sb_wready, sb_bvalid, sb_bresp
    );

    modport slave (
        input  sb_arvalid, sb_araddr, sb_rready,
        input  sb_wvalid, sb_waddr, sb_wdata, sb_wstrb, sb_bready,
        output sb_arready, sb_rvalid, sb_rdata,
        output sb_wready, sb_bvalid, sb_bresp
    );
endinterface

// File: rtl/sb_rr_arb2.sv
// Two-way round-robin arbiter for the shared SRAM port; only conflicts move the pointer.
module sb_rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req_rd,
    input  logic req_wr,
    output logic gnt_rd,
    output logic gnt_wr
);
    logic prio_rd;

    assign gnt_rd = req_rd & (~req_wr | prio_rd);
    assign gnt_wr = req_wr & (~req_rd | ~prio_rd);

    // Loser of a conflict gets priority next time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prio_rd <= 1'b0;
        else if (req_rd & req_wr)
            prio_rd <= gnt_wr;
    end
endmodule

// File: rtl/sb_sram_slv.sv
// SB-bus slave terminating AR/R and W/B onto a single-port SRAM with 1-cycle read latency.
module sb_sram_slv
    import sb_pkg::*;
#(
    parameter int          AW   = 12,
    parameter logic [31:0] BASE = 32'h2000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    sb_sram_slv_if.slave  sb,
    output logic          ram_cs,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output sb_data_t      ram_wdata,
    output sb_strb_t      ram_wbe,
    input  sb_data_t      ram_rdata
);
    sb_rd_st_t rd_r;
    sb_data_t  hold_r;
    logic      bvalid_r;
    logic      bresp_r;
    logic      rd_req, wr_req, gnt_rd, gnt_wr;
    logic      rd_in, wr_in;
    logic      unused_ok;

    function automatic logic in_rng(input sb_addr_t a);
        return a[SB_AW-1:AW+2] == BASE[SB_AW-1:AW+2];
    endfunction

    assign rd_in  = in_rng(sb.sb_araddr);
    assign wr_in  = in_rng(sb.sb_waddr);
    assign rd_req = sb.sb_arvalid & (~rd_r.vld | sb.sb_rready);
    assign wr_req = sb.sb_wvalid  & (~bvalid_r | sb.sb_bready);

    sb_rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_rd (rd_req),
        .req_wr (wr_req),
        .gnt_rd (gnt_rd),
        .gnt_wr (gnt_wr)
    );

    assign sb.sb_arready = gnt_rd;
    assign sb.sb_wready  = gnt_wr;

    assign ram_cs    = (gnt_rd & rd_in) | (gnt_wr & wr_in);
    assign ram_we    = gnt_wr;
    assign ram_addr  = gnt_wr ? sb.sb_waddr[AW+1:2] : sb.sb_araddr[AW+1:2];
    assign ram_wdata = sb.sb_wdata;
    assign ram_wbe   = gnt_wr ? sb.sb_wstrb : '0;

    // Byte-lane bits of the addresses are ignored.
    assign unused_ok = ^{sb.sb_araddr[1:0], sb.sb_waddr[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_r   <= '0;
            hold_r <= '0;
        end else begin
            if (gnt_rd) begin
                rd_r.vld   <= 1'b1;
                rd_r.first <= 1'b1;
                rd_r.err   <= ~rd_in;
            end else if (sb.sb_rready) begin
                rd_r.vld <= 1'b0;
            end
            // Stalled on the bypass beat: park the SRAM output before it can change.
            if (rd_r.vld & rd_r.first & ~sb.sb_rready) begin
                rd_r.first <= 1'b0;
                hold_r     <= ram_rdata;
            end
        end
    end

    always_comb begin
        sb.sb_rdata = '0;
        if (rd_r.vld & ~rd_r.err)
            sb.sb_rdata = rd_r.first ? ram_rdata : hold_r;
    end
    assign sb.sb_rvalid = rd_r.vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bvalid_r <= 1'b0;
            bresp_r  <= SB_RESP_OKAY;
        end else if (gnt_wr) begin
            bvalid_r <= 1'b1;
            bresp_r  <= wr_in ? SB_RESP_OKAY : SB_RESP_ERR;
        end else if (sb.sb_bready) begin
            bvalid_r <= 1'b0;
        end
    end

    assign sb.sb_bvalid = bvalid_r;
    assign sb.sb_bresp  = bresp_r;
endmodule

// File: tb/tb_sb_sram_slv.sv
// Bench for sb_sram_slv: directed scenarios plus random traffic against a transaction-level model.
module tb_sb_sram_slv;
    import sb_pkg::*;

    localparam int          AW   = 12;
    localparam logic [31:0] BASE = 32'h2000_0000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ram_cs, ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [3:0]    ram_wbe;
    logic [31:0]   ram_rdata = '0;
    logic [31:0]   sram [0:(1<<AW)-1] = '{default: 32'h0};

    always #5 clk = ~clk;

    sb_sram_slv_if sb ();

    sb_sram_slv #(.AW(AW), .BASE(BASE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sb        (sb),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_wbe   (ram_wbe),
        .ram_rdata (ram_rdata)
    );

    // SRAM macro behaviour: byte-enabled write, registered read.
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_wbe[b]) sram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_rdata <= sram[ram_addr];
            end
        end
    end

    // Reference model state
    logic [31:0] ref_mem [0:(1<<AW)-1];
    logic [31:0] rq[$];
    logic        bq[$];
    logic [31:0] got_q[$];
    logic        prio_m;
    int          n_chk = 0, n_pass = 0;

    logic        obs_rvalid, obs_bvalid, obs_bresp, obs_cs, last_gr, last_gw;
    logic [31:0] obs_rdata, obs_addr, rd_addr_obs;

    function automatic logic in_rng(input logic [31:0] a);
        return (a >> (AW + 2)) == (BASE >> (AW + 2));
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & ((32'd1 << AW) - 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step();
        logic        rd_req, wr_req, egr, egw, ecs;
        logic [31:0] wa, ra, w;
        #1;
        ra = sb.sb_araddr;
        wa = sb.sb_waddr;
        obs_rvalid = sb.sb_rvalid; obs_rdata = sb.sb_rdata;
        obs_bvalid = sb.sb_bvalid; obs_bresp = sb.sb_bresp;
        obs_cs     = ram_cs;       obs_addr  = 32'(ram_addr);
        last_gr    = sb.sb_arready; last_gw  = sb.sb_wready;

        chk("rvalid", sb.sb_rvalid, 32'(rq.size() != 0));
        if (rq.size() != 0) chk("rdata", sb.sb_rdata, rq[0]);
        chk("bvalid", sb.sb_bvalid, 32'(bq.size() != 0));
        if (bq.size() != 0) chk("bresp", sb.sb_bresp, 32'(bq[0]));

        rd_req = sb.sb_arvalid && (rq.size() == 0 || sb.sb_rready);
        wr_req = sb.sb_wvalid  && (bq.size() == 0 || sb.sb_bready);
        egr = rd_req && (!wr_req || prio_m);
        egw = wr_req && !egr;
        chk("arready", sb.sb_arready, 32'(egr));
        chk("wready",  sb.sb_wready,  32'(egw));
        ecs = (egr && in_rng(ra)) || (egw && in_rng(wa));
        chk("ram_cs", ram_cs, 32'(ecs));
        if (ecs) begin
            chk("ram_we", ram_we, 32'(egw));
            chk("ram_addr", 32'(ram_addr), 32'(widx(egw ? wa : ra)));
            if (egw) begin
                chk("ram_wdata", ram_wdata, sb.sb_wdata);
                chk("ram_wbe", 32'(ram_wbe), 32'(sb.sb_wstrb));
            end
        end
        if (rd_req && wr_req) prio_m = egw;

        if (rq.size() != 0 && sb.sb_rready) begin
            got_q.push_back(sb.sb_rdata);
            void'(rq.pop_front());
        end
        if (bq.size() != 0 && sb.sb_bready) void'(bq.pop_front());
        if (egw) begin
            if (in_rng(wa)) begin
                w = ref_mem[widx(wa)];
                for (int b = 0; b < 4; b++)
                    if (sb.sb_wstrb[b]) w[8*b +: 8] = sb.sb_wdata[8*b +: 8];
                ref_mem[widx(wa)] = w;
            end
            bq.push_back(!in_rng(wa));
        end
        if (egr) rq.push_back(in_rng(ra) ? ref_mem[widx(ra)] : 32'h0);
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        sb.sb_wvalid = 1'b1; sb.sb_waddr = a; sb.sb_wdata = d; sb.sb_wstrb = s;
        sb.sb_bready = 1'b1; sb.sb_arvalid = 1'b0;
        step();
        sb.sb_wvalid = 1'b0;
        step();
    endtask

    task automatic rd(input logic [31:0] a);
        sb.sb_arvalid = 1'b1; sb.sb_araddr = a; sb.sb_rready = 1'b1; sb.sb_wvalid = 1'b0;
        step();
        rd_addr_obs = obs_addr;
        sb.sb_arvalid = 1'b0;
        step();
    endtask

    initial begin
        logic [31:0] d [4];
        int          ar_idx [10];
        logic        rr_pat [10];

        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = 32'h0;
        prio_m = 1'b0;
        rst_n = 1'b0;
        sb.sb_arvalid = 0; sb.sb_araddr = BASE; sb.sb_rready = 1;
        sb.sb_wvalid = 0; sb.sb_waddr = BASE; sb.sb_wdata = 0; sb.sb_wstrb = 0; sb.sb_bready = 1;

        #2;
        chk("rst_rvalid", sb.sb_rvalid, 0);
        chk("rst_rdata",  sb.sb_rdata,  0);
        chk("rst_bvalid", sb.sb_bvalid, 0);
        chk("rst_bresp",  sb.sb_bresp,  0);
        chk("rst_ram_cs", ram_cs, 0);
        chk("rst_ram_we", ram_we, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Write then read back
        sb.sb_wvalid = 1; sb.sb_waddr = 32'h2000_0010; sb.sb_wdata = 32'hA5A5_1234; sb.sb_wstrb = 4'hF;
        step();
        chk("t1_wgnt", last_gw, 1);
        sb.sb_wvalid = 0;
        step();
        chk("t1_bvalid", obs_bvalid, 1);
        chk("t1_bresp", obs_bresp, 0);
        rd(32'h2000_0010);
        chk("t1_ram_addr", rd_addr_obs, 4);
        chk("t1_rvalid", obs_rvalid, 1);
        chk("t1_rdata", obs_rdata, 32'hA5A5_1234);

        // Byte strobes
        wr(32'h2000_0020, 32'hFFFF_FFFF, 4'hF);
        wr(32'h2000_0020, 32'h0000_0000, 4'b0101);
        rd(32'h2000_0020);
        chk("strb_rdata", obs_rdata, 32'hFF00_FF00);

        // Read hold: four back-to-back reads, second stalled for three cycles
        for (int i = 0; i < 4; i++) begin
            d[i] = $urandom;
            wr(BASE + 32'h100 + 32'(4 * i), d[i], 4'hF);
        end
        ar_idx = '{0, 1, 2, 2, 2, 2, 3, -1, -1, -1};
        rr_pat = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
        got_q.delete();
        for (int c = 0; c < 10; c++) begin
            sb.sb_arvalid = (ar_idx[c] >= 0);
            if (ar_idx[c] >= 0) sb.sb_araddr = BASE + 32'h100 + 32'(4 * ar_idx[c]);
            sb.sb_rready = rr_pat[c];
            step();
            if (c >= 2 && c <= 5) chk("hold_rdata", obs_rdata, d[1]);
            if (c >= 2 && c <= 4) chk("hold_arready", last_gr, 0);
        end
        chk("hold_count", got_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < got_q.size()) chk("hold_order", got_q[i], d[i]);

        // Out-of-window accesses
        sb.sb_wvalid = 1; sb.sb_waddr = 32'h3000_0000; sb.sb_wdata = 32'hDEAD_BEEF; sb.sb_wstrb = 4'hF;
        step();
        chk("oor_w_cs", obs_cs, 0);
        sb.sb_wvalid = 0;
        step();
        chk("oor_bresp", obs_bresp, 1);
        rd(32'h3000_0040);
        chk("oor_rvalid", obs_rvalid, 1);
        chk("oor_rdata", obs_rdata, 0);

        // Random mixed traffic
        for (int c = 0; c < 400; c++) begin
            sb.sb_arvalid = ($urandom_range(9) < 6);
            sb.sb_wvalid  = ($urandom_range(9) < 6);
            sb.sb_rready  = ($urandom_range(9) < 7);
            sb.sb_bready  = ($urandom_range(9) < 7);
            sb.sb_araddr  = ($urandom_range(9) == 0 ? 32'h3000_0000 : BASE) | 32'($urandom_range(63) << 2) | 32'($urandom_range(3));
            sb.sb_waddr   = ($urandom_range(9) == 0 ? 32'h3000_0000 : BASE) | 32'($urandom_range(63) << 2);
            sb.sb_wdata   = $urandom;
            sb.sb_wstrb   = 4'($urandom_range(15));
            step();
        end
        sb.sb_arvalid = 0; sb.sb_wvalid = 0; sb.sb_rready = 1; sb.sb_bready = 1;
        repeat (3) step();
        chk("drain_r", rq.size(), 0);
        chk("drain_b", bq.size(), 0);

        // Reset with both responses pending
        sb.sb_arvalid = 1; sb.sb_araddr = BASE + 32'h40; sb.sb_rready = 0;
        sb.sb_wvalid = 1; sb.sb_waddr = BASE + 32'h44; sb.sb_wdata = 32'h1234_5678;
        sb.sb_wstrb = 4'hF; sb.sb_bready = 0;
        repeat (2) step();
        chk("pre_rst_rvalid", sb.sb_rvalid, 1);
        chk("pre_rst_bvalid", sb.sb_bvalid, 1);
        sb.sb_arvalid = 0; sb.sb_wvalid = 0;
        #3 rst_n = 1'b0;
        #1;
        chk("async_rvalid", sb.sb_rvalid, 0);
        chk("async_bvalid", sb.sb_bvalid, 0);
        chk("async_rdata", sb.sb_rdata, 0);
        rq.delete(); bq.delete(); prio_m = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Conflict after reset: write wins first, then alternate
        sb.sb_arvalid = 1; sb.sb_araddr = BASE + 32'h80; sb.sb_rready = 1;
        sb.sb_wvalid = 1; sb.sb_waddr = BASE + 32'h84; sb.sb_bready = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("conflict_w", last_gw, 32'(i % 2 == 0));
            chk("conflict_r", last_gr, 32'(i % 2 == 1));
            chk("conflict_cs", obs_cs, 1);
        end
        sb.sb_arvalid = 0; sb.sb_wvalid = 0;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
